// File: rtl/mem_access_unit_if.sv
// Signal bundle between the CPU memory stage, the word-wide data bus and the
// downstream read-data decoder. The unit takes the slave view; the environment the master.
interface mem_access_unit_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_size;
  logic        cpu_ext;
  logic        cpu_stall;
  logic        cpu_done;
  logic        cpu_err;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_ben;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic [31:0] rd_word;
  logic [1:0]  rd_offset;
  logic [1:0]  rd_size;
  logic        rd_ext;
  logic        rd_valid;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_ext, bus_ack, bus_rdata,
    input  cpu_stall, cpu_done, cpu_err, bus_req, bus_we, bus_addr, bus_wdata, bus_ben,
    input  rd_word, rd_offset, rd_size, rd_ext, rd_valid
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_ext, bus_ack, bus_rdata,
    output cpu_stall, cpu_done, cpu_err, bus_req, bus_we, bus_addr, bus_wdata, bus_ben,
    output rd_word, rd_offset, rd_size, rd_ext, rd_valid
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer: alignment check, big-endian lane placement,
// req/ack bus handshake with timeout, and capture of the raw load word for the decoder.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rst_n,
  mem_access_unit_if.slave memIf
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  localparam logic [9:0] LAST_COUNT = 10'(TIMEOUT_CYCLES - 1);

  stateT       state;
  stateT       nextState;
  logic [9:0]  timeoutCnt;
  logic        errFlag;
  logic [29:0] addrReg;
  logic [3:0]  benReg;
  logic [31:0] wdataReg;
  logic        weReg;
  logic [1:0]  offsetReg;
  logic [1:0]  sizeReg;
  logic        extReg;
  logic [31:0] rdWord;
  logic [1:0]  rdOffset;
  logic [1:0]  rdSize;
  logic        rdExt;

  logic        misaligned;
  logic [3:0]  benCalc;
  logic [31:0] wdataCalc;
  logic        accept;
  logic        reject;
  logic        ackHit;
  logic        expire;

  // Lane placement: offset 0 is the most significant byte of the bus word.
  always_comb begin
    misaligned = 1'b0;
    benCalc    = 4'b0000;
    wdataCalc  = 32'h0;
    case (memIf.cpu_size)
      2'd0: begin
        misaligned = (memIf.cpu_addr[1:0] != 2'b00);
        benCalc    = 4'b1111;
        wdataCalc  = memIf.cpu_wdata;
      end
      2'd1: begin
        misaligned = memIf.cpu_addr[0];
        benCalc    = memIf.cpu_addr[1] ? 4'b0011 : 4'b1100;
        wdataCalc  = {2{memIf.cpu_wdata[15:0]}};
      end
      2'd2: begin
        benCalc   = 4'b1000 >> memIf.cpu_addr[1:0];
        wdataCalc = {4{memIf.cpu_wdata[7:0]}};
      end
      default: misaligned = 1'b1;
    endcase
    if (!memIf.cpu_we) wdataCalc = 32'h0;
  end

  assign accept = (state == IDLE) && memIf.cpu_req && !misaligned;
  assign reject = (state == IDLE) && memIf.cpu_req && misaligned;
  assign ackHit = (state == WAIT) && memIf.bus_ack;
  assign expire = (state == WAIT) && !memIf.bus_ack && (timeoutCnt == LAST_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // An ack in the final wait cycle takes priority over the timeout.
  always_comb begin
    nextState       = state;
    memIf.cpu_stall = 1'b0;
    memIf.cpu_done  = 1'b0;
    memIf.cpu_err   = 1'b0;
    memIf.bus_req   = 1'b0;
    memIf.rd_valid  = 1'b0;
    case (state)
      IDLE: begin
        memIf.cpu_stall = memIf.cpu_req;
        if (accept)      nextState = WAIT;
        else if (reject) nextState = RESP;
      end
      WAIT: begin
        memIf.cpu_stall = 1'b1;
        memIf.bus_req   = 1'b1;
        if (ackHit || expire) nextState = RESP;
      end
      RESP: begin
        memIf.cpu_done = 1'b1;
        memIf.cpu_err  = errFlag;
        memIf.rd_valid = !weReg && !errFlag;
        nextState      = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // The rd_* tuple only moves on a successful load so the decoder keeps its last good word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeoutCnt <= 10'd0;
      errFlag    <= 1'b0;
      addrReg    <= 30'd0;
      benReg     <= 4'b0000;
      wdataReg   <= 32'h0;
      weReg      <= 1'b0;
      offsetReg  <= 2'd0;
      sizeReg    <= 2'd0;
      extReg     <= 1'b0;
      rdWord     <= 32'h0;
      rdOffset   <= 2'd0;
      rdSize     <= 2'd0;
      rdExt      <= 1'b0;
    end else begin
      if (accept) begin
        addrReg    <= memIf.cpu_addr[31:2];
        benReg     <= benCalc;
        wdataReg   <= wdataCalc;
        weReg      <= memIf.cpu_we;
        offsetReg  <= memIf.cpu_addr[1:0];
        sizeReg    <= memIf.cpu_size;
        extReg     <= memIf.cpu_ext;
        timeoutCnt <= 10'd0;
        errFlag    <= 1'b0;
      end else if (reject) begin
        errFlag <= 1'b1;
      end
      if ((state == WAIT) && !memIf.bus_ack) begin
        timeoutCnt <= timeoutCnt + 10'd1;
        if (expire) errFlag <= 1'b1;
      end
      if (ackHit && !weReg) begin
        rdWord   <= memIf.bus_rdata;
        rdOffset <= offsetReg;
        rdSize   <= sizeReg;
        rdExt    <= extReg;
      end
    end
  end

  assign memIf.bus_we    = weReg;
  assign memIf.bus_addr  = {addrReg, 2'b00};
  assign memIf.bus_wdata = wdataReg;
  assign memIf.bus_ben   = benReg;
  assign memIf.rd_word   = rdWord;
  assign memIf.rd_offset = rdOffset;
  assign memIf.rd_size   = rdSize;
  assign memIf.rd_ext    = rdExt;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// accesses compared against a byte-lane reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic clk;
  logic rst_n;

  mem_access_unit_if memIf();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .memIf(memIf)
  );

  int checks   = 0;
  int errors   = 0;
  int cycleNum = 0;

  // Reference copy of the decoder tuple (last successful load)
  logic [31:0] mWord   = 32'h0;
  logic [1:0]  mOffset = 2'd0;
  logic [1:0]  mSize   = 2'd0;
  logic        mExt    = 1'b0;

  int          obsDone, obsStall, obsBusCycles, obsDoneAbs, obsBusAbs;
  logic        obsErr, obsRdValid, obsWe, obsRdExt;
  logic [31:0] obsAddr, obsWdata, obsRdWord;
  logic [3:0]  obsBen;
  logic [1:0]  obsRdOffset, obsRdSize;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cycleNum++;
  endtask

  function automatic int nBytes(logic [1:0] s);
    return 4 >> s;
  endfunction

  function automatic logic expErr(logic [31:0] a, logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    return (int'(a[1:0]) % nBytes(s)) != 0;
  endfunction

  function automatic logic [3:0] expBen(logic [31:0] a, logic [1:0] s);
    int nb;
    int off;
    if (s == 2'd3) return 4'b0000;
    nb  = nBytes(s);
    off = int'(a[1:0]);
    return 4'(((1 << nb) - 1) << (4 - off - nb));
  endfunction

  function automatic logic [31:0] expWdata(logic we, logic [31:0] wd, logic [1:0] s);
    logic [31:0] r;
    int nb;
    r = 32'h0;
    if (!we || s == 2'd3) return r;
    nb = nBytes(s);
    for (int i = 0; i < 4; i++) r[31-8*i -: 8] = wd[8*(nb-1-(i%nb)) +: 8];
    return r;
  endfunction

  // Drives one access and records what the DUT did; leaves the bench in the cycle after done.
  task automatic runAccess(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] size, input logic ext, input int ackDelay,
                           input logic [31:0] rdata, input logic holdReq);
    int cyc;
    logic fin;
    cyc = 0; fin = 1'b0;
    obsDone = -1; obsStall = 0; obsBusCycles = 0; obsDoneAbs = -1; obsBusAbs = -1;
    obsErr = 1'bx; obsRdValid = 1'bx;
    memIf.cpu_we = we; memIf.cpu_addr = addr; memIf.cpu_wdata = wd;
    memIf.cpu_size = size; memIf.cpu_ext = ext; memIf.cpu_req = 1'b1;
    while (!fin && cyc < 100) begin
      #1;
      if (memIf.cpu_stall) obsStall++;
      if (memIf.cpu_done) begin
        obsDone = cyc; obsDoneAbs = cycleNum; obsErr = memIf.cpu_err; obsRdValid = memIf.rd_valid;
        obsRdWord = memIf.rd_word; obsRdOffset = memIf.rd_offset;
        obsRdSize = memIf.rd_size; obsRdExt = memIf.rd_ext;
        fin = 1'b1;
        memIf.bus_ack = 1'b0;
        if (!holdReq) memIf.cpu_req = 1'b0;
      end else if (memIf.bus_req) begin
        if (obsBusCycles == 0) begin
          obsBusAbs = cycleNum; obsAddr = memIf.bus_addr; obsWdata = memIf.bus_wdata;
          obsBen = memIf.bus_ben; obsWe = memIf.bus_we;
        end
        memIf.bus_ack   = (obsBusCycles == ackDelay);
        memIf.bus_rdata = memIf.bus_ack ? rdata : $urandom;
        obsBusCycles++;
      end else begin
        memIf.bus_ack = 1'b0;
      end
      step();
      cyc++;
    end
    memIf.bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    memIf.cpu_req = 1'b1; memIf.cpu_we = 1'b0; memIf.cpu_addr = 32'h0; memIf.cpu_wdata = 32'h0;
    memIf.cpu_size = 2'd0; memIf.cpu_ext = 1'b0; memIf.bus_ack = 1'b0; memIf.bus_rdata = 32'h0;
    step(); step();
    checks++; if (memIf.cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset.stall got %b want 1", memIf.cpu_stall); end
    checks++;
    if ({memIf.bus_req, memIf.bus_we, memIf.bus_addr, memIf.bus_wdata, memIf.bus_ben, memIf.cpu_done,
         memIf.cpu_err, memIf.rd_word, memIf.rd_offset, memIf.rd_size, memIf.rd_ext, memIf.rd_valid} !== '0) begin
      errors++;
      $display("[TB] FAIL reset.outputs got req=%b addr=%h wdata=%h ben=%b done=%b rdWord=%h want all zero",
               memIf.bus_req, memIf.bus_addr, memIf.bus_wdata, memIf.bus_ben, memIf.cpu_done, memIf.rd_word);
    end
    memIf.cpu_req = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_byte();
    runAccess(1'b0, 32'h1003, 32'h0, 2'd2, 1'b0, 0, 32'h112233F4, 1'b0);
    mWord = 32'h112233F4; mOffset = 2'd3; mSize = 2'd2; mExt = 1'b0;
    checks++; if (obsBusAbs < 0 || obsAddr !== 32'h1000) begin errors++; $display("[TB] FAIL loadByte.busAddr got %h want 00001000", obsAddr); end
    checks++; if (obsBen !== 4'b0001) begin errors++; $display("[TB] FAIL loadByte.ben got %b want 0001", obsBen); end
    checks++; if (obsDone !== 2) begin errors++; $display("[TB] FAIL loadByte.doneCycle got %0d want 2", obsDone); end
    checks++; if (obsRdValid !== 1'b1) begin errors++; $display("[TB] FAIL loadByte.rdValid got %b want 1", obsRdValid); end
    checks++;
    if ({obsRdWord, obsRdOffset, obsRdSize, obsRdExt} !== {mWord, mOffset, mSize, mExt}) begin
      errors++;
      $display("[TB] FAIL loadByte.rdTuple got %h/%0d/%0d/%b want %h/%0d/%0d/%b",
               obsRdWord, obsRdOffset, obsRdSize, obsRdExt, mWord, mOffset, mSize, mExt);
    end
    checks++; if (obsStall !== 2) begin errors++; $display("[TB] FAIL loadByte.stallCycles got %0d want 2", obsStall); end
  endtask

  task automatic test_store_halfword();
    runAccess(1'b1, 32'h2002, 32'hDEADBEEF, 2'd1, 1'b0, 0, 32'h0, 1'b0);
    checks++; if (obsWdata !== 32'hBEEFBEEF) begin errors++; $display("[TB] FAIL storeHalf.wdata got %h want BEEFBEEF", obsWdata); end
    checks++; if (obsBen !== 4'b0011 || obsWe !== 1'b1) begin errors++; $display("[TB] FAIL storeHalf.benWe got %b/%b want 0011/1", obsBen, obsWe); end
    checks++; if (obsDone !== 2) begin errors++; $display("[TB] FAIL storeHalf.doneCycle got %0d want 2", obsDone); end
    checks++; if (obsRdValid !== 1'b0) begin errors++; $display("[TB] FAIL storeHalf.rdValid got %b want 0", obsRdValid); end
    checks++; if (obsRdWord !== mWord) begin errors++; $display("[TB] FAIL storeHalf.rdWord got %h want %h", obsRdWord, mWord); end
  endtask

  task automatic test_misaligned();
    runAccess(1'b0, 32'h3001, 32'h0, 2'd0, 1'b0, 0, 32'h0, 1'b0);
    checks++; if (obsDone !== 1 || obsErr !== 1'b1) begin errors++; $display("[TB] FAIL misalignWord.doneErr got %0d/%b want 1/1", obsDone, obsErr); end
    checks++; if (obsBusCycles !== 0) begin errors++; $display("[TB] FAIL misalignWord.busReq got %0d cycles want 0", obsBusCycles); end
    runAccess(1'b1, 32'h0, 32'h12345678, 2'd3, 1'b0, 0, 32'h0, 1'b0);
    checks++; if (obsDone !== 1 || obsErr !== 1'b1) begin errors++; $display("[TB] FAIL illegalSize.doneErr got %0d/%b want 1/1", obsDone, obsErr); end
    checks++; if (obsBusCycles !== 0) begin errors++; $display("[TB] FAIL illegalSize.busReq got %0d cycles want 0", obsBusCycles); end
  endtask

  task automatic test_timeout();
    int lateHits;
    logic [31:0] rd;
    runAccess(1'b0, 32'h0000_0104, 32'h0, 2'd0, 1'b1, -1, 32'h0, 1'b0);
    checks++; if (obsBusCycles !== TO) begin errors++; $display("[TB] FAIL timeout.busReqCycles got %0d want %0d", obsBusCycles, TO); end
    checks++; if (obsDone !== TO + 1 || obsErr !== 1'b1) begin errors++; $display("[TB] FAIL timeout.doneErr got %0d/%b want %0d/1", obsDone, obsErr, TO + 1); end
    checks++; if (obsRdValid !== 1'b0 || obsRdWord !== mWord) begin errors++; $display("[TB] FAIL timeout.rd got %b/%h want 0/%h", obsRdValid, obsRdWord, mWord); end
    memIf.bus_ack = 1'b1; memIf.bus_rdata = 32'hBAD0BAD0;
    step();
    memIf.bus_ack = 1'b0;
    lateHits = 0;
    for (int i = 0; i < 3; i++) begin
      if (memIf.cpu_done || memIf.bus_req || memIf.rd_word !== mWord) lateHits++;
      step();
    end
    checks++; if (lateHits !== 0) begin errors++; $display("[TB] FAIL timeout.lateAck got %0d reactions want 0", lateHits); end
    rd = $urandom;
    runAccess(1'b0, 32'h0000_0040, 32'h0, 2'd0, 1'b0, 1, rd, 1'b0);
    mWord = rd; mOffset = 2'd0; mSize = 2'd0; mExt = 1'b0;
    checks++; if (obsDone !== 3 || obsErr !== 1'b0 || obsRdWord !== rd) begin
      errors++; $display("[TB] FAIL timeout.nextAccess got done=%0d err=%b word=%h want 3/0/%h", obsDone, obsErr, obsRdWord, rd);
    end
  endtask

  task automatic test_reset_mid_access();
    int spurious;
    runAccess(1'b0, 32'h0000_0080, 32'h0, 2'd0, 1'b0, 3, 32'h5A5A_0F0F, 1'b0);
    mWord = 32'h5A5A_0F0F; mOffset = 2'd0; mSize = 2'd0; mExt = 1'b0;
    checks++; if (obsDone !== 5 || obsErr !== 1'b0 || obsRdWord !== mWord) begin
      errors++; $display("[TB] FAIL waitStates.first got done=%0d err=%b word=%h want 5/0/%h", obsDone, obsErr, obsRdWord, mWord);
    end
    memIf.cpu_we = 1'b1; memIf.cpu_addr = 32'h84; memIf.cpu_wdata = 32'h1; memIf.cpu_size = 2'd0;
    memIf.cpu_req = 1'b1;
    step(); step();
    checks++; if (memIf.bus_req !== 1'b1) begin errors++; $display("[TB] FAIL midReset.inWait got bus_req %b want 1", memIf.bus_req); end
    memIf.cpu_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    mWord = 32'h0; mOffset = 2'd0; mSize = 2'd0; mExt = 1'b0;
    checks++; if (memIf.bus_req !== 1'b0) begin errors++; $display("[TB] FAIL midReset.busReq got %b want 0", memIf.bus_req); end
    checks++;
    if ({memIf.bus_we, memIf.bus_addr, memIf.bus_wdata, memIf.bus_ben, memIf.cpu_done, memIf.cpu_err,
         memIf.cpu_stall, memIf.rd_word, memIf.rd_offset, memIf.rd_size, memIf.rd_ext, memIf.rd_valid} !== '0) begin
      errors++;
      $display("[TB] FAIL midReset.outputs got we=%b addr=%h ben=%b done=%b stall=%b rdWord=%h want all zero",
               memIf.bus_we, memIf.bus_addr, memIf.bus_ben, memIf.cpu_done, memIf.cpu_stall, memIf.rd_word);
    end
    step(); step();
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (memIf.cpu_done || memIf.cpu_err || memIf.bus_req) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("[TB] FAIL midReset.noDone got %0d pulses want 0", spurious); end
  endtask

  task automatic test_back_to_back();
    int loadDoneAbs;
    logic [31:0] wd;
    runAccess(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 0, 32'hCAFEF00D, 1'b1);
    loadDoneAbs = obsDoneAbs;
    mWord = 32'hCAFEF00D; mOffset = 2'd0; mSize = 2'd0; mExt = 1'b0;
    checks++; if (obsRdWord !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL b2b.rdWord got %h want CAFEF00D", obsRdWord); end
    wd = $urandom;
    runAccess(1'b1, 32'h5, wd, 2'd2, 1'b0, 0, 32'h0, 1'b0);
    checks++; if (obsBusAbs - loadDoneAbs !== 2) begin errors++; $display("[TB] FAIL b2b.gap got %0d want 2", obsBusAbs - loadDoneAbs); end
    checks++; if (obsBen !== 4'b0100 || obsAddr !== 32'h4) begin errors++; $display("[TB] FAIL b2b.benAddr got %b/%h want 0100/00000004", obsBen, obsAddr); end
    checks++; if (obsWdata !== {4{wd[7:0]}}) begin errors++; $display("[TB] FAIL b2b.wdata got %h want %h", obsWdata, {4{wd[7:0]}}); end
  endtask

  task automatic test_random();
    logic we, ext, e, alignErr;
    logic [31:0] addr, wd, rd;
    logic [1:0] size;
    int delay, wantDone, wantBus;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom); ext = 1'($urandom); addr = $urandom; wd = $urandom; rd = $urandom;
      size = 2'($urandom_range(0, 3));
      delay = $urandom_range(0, TO + 1);
      alignErr = expErr(addr, size);
      if (alignErr)         begin wantDone = 1;         wantBus = 0;         e = 1'b1; end
      else if (delay < TO)  begin wantDone = delay + 2; wantBus = delay + 1; e = 1'b0; end
      else                  begin wantDone = TO + 1;    wantBus = TO;        e = 1'b1; end
      runAccess(we, addr, wd, size, ext, delay, rd, 1'b0);
      if (!e && !we) begin mWord = rd; mOffset = addr[1:0]; mSize = size; mExt = ext; end
      checks++; if (obsDone !== wantDone || obsErr !== e) begin errors++; $display("[TB] FAIL rand%0d.doneErr got %0d/%b want %0d/%b", n, obsDone, obsErr, wantDone, e); end
      checks++; if (obsBusCycles !== wantBus) begin errors++; $display("[TB] FAIL rand%0d.busCycles got %0d want %0d", n, obsBusCycles, wantBus); end
      checks++; if (obsRdValid !== (!e && !we)) begin errors++; $display("[TB] FAIL rand%0d.rdValid got %b want %b", n, obsRdValid, !e && !we); end
      checks++;
      if ({obsRdWord, obsRdOffset, obsRdSize, obsRdExt} !== {mWord, mOffset, mSize, mExt}) begin
        errors++;
        $display("[TB] FAIL rand%0d.rdTuple got %h/%0d/%0d/%b want %h/%0d/%0d/%b", n,
                 obsRdWord, obsRdOffset, obsRdSize, obsRdExt, mWord, mOffset, mSize, mExt);
      end
      if (!alignErr) begin
        checks++;
        if ({obsAddr, obsBen, obsWdata, obsWe} !== {addr[31:2], 2'b00, expBen(addr, size), expWdata(we, wd, size), we}) begin
          errors++;
          $display("[TB] FAIL rand%0d.bus got %h/%b/%h/%b want %h/%b/%h/%b", n, obsAddr, obsBen, obsWdata, obsWe,
                   {addr[31:2], 2'b00}, expBen(addr, size), expWdata(we, wd, size), we);
        end
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) step();
    end
  endtask

  initial begin
    $display("[TB] mem_access_unit bench start, TIMEOUT_CYCLES=%0d", TO);
    test_reset();
    test_load_byte();
    test_store_halfword();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
